// File: rtl/udp_axis_pkg.sv
// Shared types and constants for the UDP stream multiplexer/packetizer.
// Packet layout on the payload stream: prefix bytes, then channel data bytes.
package udp_axis_pkg;

  typedef enum logic [1:0] {StIdle, StHdr, StPrefix, StData} state_e;

  localparam int unsigned PREFIX_BYTES  = 6;
  localparam int unsigned UDP_HDR_BYTES = 8;
  localparam int unsigned PAYLOAD_WIDTH = 8;

  localparam logic [31:0] DEFAULT_LOCAL_IP    = 32'hC0A8_0180;  // 192.168.1.128
  localparam logic [15:0] DEFAULT_SOURCE_PORT = 16'd1234;
  localparam logic [7:0]  DEFAULT_TTL         = 8'd64;

endpackage

// File: rtl/udp_axis_word_serializer.sv
// Splits one DATA_WIDTH word into bytes, MSB first. A new word may load in the
// same cycle the previous word's last byte is accepted, so words stream gap-free.
module udp_axis_word_serializer
  import udp_axis_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  load_valid,
  input  logic [DATA_WIDTH-1:0] load_data,
  input  logic                  load_last,
  output logic                  load_ready,
  output logic [7:0]            out_tdata,
  output logic                  out_tvalid,
  output logic                  out_tlast,
  input  logic                  out_tready
);

  localparam int unsigned Bytes = DATA_WIDTH / PAYLOAD_WIDTH;
  localparam int unsigned CntW  = $clog2(Bytes + 1);

  logic [DATA_WIDTH-1:0] shreg_q;
  logic [CntW-1:0]       cnt_q;
  logic                  last_q;

  assign out_tvalid = (cnt_q != '0);
  assign out_tdata  = shreg_q[DATA_WIDTH-1 -: 8];
  assign out_tlast  = last_q && (cnt_q == CntW'(1));
  assign load_ready = (cnt_q == '0) || ((cnt_q == CntW'(1)) && out_tready);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      shreg_q <= '0;
      cnt_q   <= '0;
      last_q  <= 1'b0;
    end else if (load_valid && load_ready) begin
      shreg_q <= load_data;
      cnt_q   <= CntW'(Bytes);
      last_q  <= load_last;
    end else if (out_tvalid && out_tready) begin
      shreg_q <= shreg_q << 8;
      cnt_q   <= cnt_q - CntW'(1);
    end
  end

endmodule

// File: rtl/udp_axis_mux_packetizer.sv
// Round-robin multiplexer of N word streams into UDP packets: one header,
// a 6-byte prefix (sequence, channel, word count - 1), then the channel's words.
module udp_axis_mux_packetizer
  import udp_axis_pkg::*;
#(
  parameter int unsigned NUM_CHANNELS     = 4,
  parameter int unsigned DATA_WIDTH       = 32,
  parameter int unsigned WORDS_PER_PACKET = 16,
  parameter logic [31:0] LOCAL_IP         = DEFAULT_LOCAL_IP,
  parameter logic [15:0] SOURCE_PORT      = DEFAULT_SOURCE_PORT
) (
  input  logic                                   clk,
  input  logic                                   reset_n,
  input  logic [31:0]                            dest_ip,
  input  logic [15:0]                            dest_port,
  output logic                                   hdr_valid,
  input  logic                                   hdr_ready,
  output logic [5:0]                             hdr_dscp,
  output logic [1:0]                             hdr_ecn,
  output logic [7:0]                             hdr_ttl,
  output logic [31:0]                            hdr_source_ip,
  output logic [31:0]                            hdr_dest_ip,
  output logic [15:0]                            hdr_source_port,
  output logic [15:0]                            hdr_dest_port,
  output logic [15:0]                            hdr_length,
  output logic [15:0]                            hdr_checksum,
  output logic [7:0]                             payload_tdata,
  output logic                                   payload_tvalid,
  input  logic                                   payload_tready,
  output logic                                   payload_tlast,
  output logic                                   payload_tkeep,
  output logic                                   payload_tstrb,
  output logic                                   payload_tuser,
  output logic                                   payload_tid,
  output logic                                   payload_tdest,
  input  logic [NUM_CHANNELS-1:0][DATA_WIDTH-1:0] in_tdata,
  input  logic [NUM_CHANNELS-1:0]                in_tvalid,
  output logic [NUM_CHANNELS-1:0]                in_tready,
  output logic [31:0]                            tx_packet_count
);

  localparam int unsigned ChW  = (NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1;
  localparam int unsigned WcW  = $clog2(WORDS_PER_PACKET + 1);
  localparam int unsigned PcW  = $clog2(PREFIX_BYTES + 1);
  localparam int unsigned PfxW = PREFIX_BYTES * 8;
  localparam logic [15:0] UdpLength =
      16'(UDP_HDR_BYTES + PREFIX_BYTES + WORDS_PER_PACKET * DATA_WIDTH / 8);

  if (NUM_CHANNELS < 1 || NUM_CHANNELS > 16) begin : gen_bad_channels
    $error("NUM_CHANNELS must be in 1..16");
  end
  if (DATA_WIDTH < 8 || DATA_WIDTH > 64 || (DATA_WIDTH % 8) != 0) begin : gen_bad_width
    $error("DATA_WIDTH must be a multiple of 8 in 8..64");
  end
  if (WORDS_PER_PACKET < 1 || WORDS_PER_PACKET > 256) begin : gen_bad_words
    $error("WORDS_PER_PACKET must be in 1..256");
  end
  if (PAYLOAD_WIDTH != 8) begin : gen_bad_payload
    $error("payload stream must be 8 bits wide");
  end

  state_e                          state_q;
  logic [ChW-1:0]                  grant_q;  // doubles as last_grant between packets
  logic                            hdr_valid_q;
  logic [31:0]                     dest_ip_q;
  logic [15:0]                     dest_port_q;
  logic [PfxW-1:0]                 prefix_q;
  logic [PcW-1:0]                  pcnt_q;
  logic [WcW-1:0]                  word_cnt_q;
  logic [NUM_CHANNELS-1:0][31:0]   seq_q;
  logic [31:0]                     tx_packet_count_q;

  logic [ChW-1:0] next_grant;
  logic           grant_found;
  int unsigned    idx;

  always_comb begin
    next_grant  = grant_q;
    grant_found = 1'b0;
    idx         = 0;
    for (int unsigned i = 1; i <= NUM_CHANNELS; i++) begin
      idx = (32'(grant_q) + i) % NUM_CHANNELS;
      if (!grant_found && in_tvalid[ChW'(idx)]) begin
        grant_found = 1'b1;
        next_grant  = ChW'(idx);
      end
    end
  end

  logic word_open, ser_load_valid, ser_load_ready, word_fire;
  logic [7:0] ser_tdata;
  logic ser_tvalid, ser_tlast, ser_tready;

  assign word_open      = (state_q == StData) && (word_cnt_q < WcW'(WORDS_PER_PACKET));
  assign ser_load_valid = word_open && in_tvalid[grant_q];
  assign word_fire      = ser_load_valid && ser_load_ready;
  assign ser_tready     = (state_q == StData) && payload_tready;

  always_comb begin
    in_tready = '0;
    if (word_open && ser_load_ready) in_tready[grant_q] = 1'b1;
  end

  udp_axis_word_serializer #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_ser (
    .clk        (clk),
    .reset_n    (reset_n),
    .load_valid (ser_load_valid),
    .load_data  (in_tdata[grant_q]),
    .load_last  (word_cnt_q == WcW'(WORDS_PER_PACKET - 1)),
    .load_ready (ser_load_ready),
    .out_tdata  (ser_tdata),
    .out_tvalid (ser_tvalid),
    .out_tlast  (ser_tlast),
    .out_tready (ser_tready)
  );

  assign payload_tvalid = (state_q == StPrefix) || ((state_q == StData) && ser_tvalid);
  assign payload_tdata  = (state_q == StPrefix) ? prefix_q[PfxW-1 -: 8] : ser_tdata;
  assign payload_tlast  = (state_q == StData) && ser_tlast;
  assign payload_tkeep  = 1'b1;
  assign payload_tstrb  = 1'b1;
  assign payload_tuser  = 1'b0;
  assign payload_tid    = 1'b0;
  assign payload_tdest  = 1'b0;

  assign hdr_valid       = hdr_valid_q;
  assign hdr_dscp        = 6'd0;
  assign hdr_ecn         = 2'd0;
  assign hdr_ttl         = DEFAULT_TTL;
  assign hdr_source_ip   = LOCAL_IP;
  assign hdr_dest_ip     = dest_ip_q;
  assign hdr_source_port = SOURCE_PORT;
  assign hdr_dest_port   = dest_port_q;
  assign hdr_length      = UdpLength;
  assign hdr_checksum    = 16'd0;
  assign tx_packet_count = tx_packet_count_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q           <= StIdle;
      grant_q           <= ChW'(NUM_CHANNELS - 1);
      hdr_valid_q       <= 1'b0;
      dest_ip_q         <= '0;
      dest_port_q       <= '0;
      prefix_q          <= '0;
      pcnt_q            <= '0;
      word_cnt_q        <= '0;
      seq_q             <= '0;
      tx_packet_count_q <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (grant_found) begin
            grant_q     <= next_grant;
            dest_ip_q   <= dest_ip;
            dest_port_q <= dest_port;
            prefix_q    <= {seq_q[next_grant], 8'(next_grant), 8'(WORDS_PER_PACKET - 1)};
            hdr_valid_q <= 1'b1;
            state_q     <= StHdr;
          end
        end
        StHdr: begin
          if (hdr_ready) begin
            hdr_valid_q <= 1'b0;
            pcnt_q      <= PcW'(PREFIX_BYTES);
            state_q     <= StPrefix;
          end
        end
        StPrefix: begin
          if (payload_tready) begin
            prefix_q <= prefix_q << 8;
            pcnt_q   <= pcnt_q - PcW'(1);
            if (pcnt_q == PcW'(1)) begin
              word_cnt_q <= '0;
              state_q    <= StData;
            end
          end
        end
        StData: begin
          if (word_fire) word_cnt_q <= word_cnt_q + WcW'(1);
          if (payload_tlast && payload_tready) begin
            seq_q[grant_q]    <= seq_q[grant_q] + 32'd1;
            tx_packet_count_q <= tx_packet_count_q + 32'd1;
            state_q           <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_udp_axis_mux_packetizer.sv
// Directed bench with a byte/header scoreboard for udp_axis_mux_packetizer.
// Sources and sinks are driven on the falling edge and sampled 1 ns before the rising edge.
module tb_udp_axis_mux_packetizer;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  logic [31:0] dest_ip = 32'h0A00_0001;
  logic [15:0] dest_port = 16'd5000;
  logic hdr_valid, hdr_ready;
  logic [5:0] hdr_dscp;
  logic [1:0] hdr_ecn;
  logic [7:0] hdr_ttl;
  logic [31:0] hdr_source_ip, hdr_dest_ip;
  logic [15:0] hdr_source_port, hdr_dest_port, hdr_length, hdr_checksum;
  logic [7:0] payload_tdata;
  logic payload_tvalid, payload_tready, payload_tlast, payload_tkeep, payload_tstrb;
  logic payload_tuser, payload_tid, payload_tdest;
  logic [3:0][31:0] in_tdata;
  logic [3:0] in_tvalid, in_tready;
  logic [31:0] tx_packet_count;

  udp_axis_mux_packetizer dut (
    .clk             (clk),
    .reset_n         (reset_n),
    .dest_ip         (dest_ip),
    .dest_port       (dest_port),
    .hdr_valid       (hdr_valid),
    .hdr_ready       (hdr_ready),
    .hdr_dscp        (hdr_dscp),
    .hdr_ecn         (hdr_ecn),
    .hdr_ttl         (hdr_ttl),
    .hdr_source_ip   (hdr_source_ip),
    .hdr_dest_ip     (hdr_dest_ip),
    .hdr_source_port (hdr_source_port),
    .hdr_dest_port   (hdr_dest_port),
    .hdr_length      (hdr_length),
    .hdr_checksum    (hdr_checksum),
    .payload_tdata   (payload_tdata),
    .payload_tvalid  (payload_tvalid),
    .payload_tready  (payload_tready),
    .payload_tlast   (payload_tlast),
    .payload_tkeep   (payload_tkeep),
    .payload_tstrb   (payload_tstrb),
    .payload_tuser   (payload_tuser),
    .payload_tid     (payload_tid),
    .payload_tdest   (payload_tdest),
    .in_tdata        (in_tdata),
    .in_tvalid       (in_tvalid),
    .in_tready       (in_tready),
    .tx_packet_count (tx_packet_count)
  );

  typedef struct { logic [7:0] data; logic last; } exp_byte_t;
  typedef struct { logic [31:0] ip; logic [15:0] port; } exp_hdr_t;

  exp_byte_t exp_q[$];
  exp_hdr_t  hq[$];
  int n_checks = 0;
  int n_fail = 0;
  int hdr_budget = 0;
  int pay_hs = 0;
  logic hold_hdr = 1'b0;
  logic [3:0] src_en = '0;
  int gap_pct = 0;
  int rdy_pct = 100;
  int src_ptr [4] = '{0, 0, 0, 0};
  logic [3:0] src_hs = '0;
  logic [31:0] m_seq [4] = '{0, 0, 0, 0};
  int m_ptr [4] = '{0, 0, 0, 0};

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] byte_of(int c, int k, int j);
    return 8'(c * 64 + 4 * k + j);
  endfunction

  function automatic logic [31:0] word_of(int c, int k);
    return {byte_of(c, k, 0), byte_of(c, k, 1), byte_of(c, k, 2), byte_of(c, k, 3)};
  endfunction

  task automatic push_byte(input logic [7:0] d, input logic l);
    exp_byte_t e;
    e.data = d;
    e.last = l;
    exp_q.push_back(e);
  endtask

  // Expected packet: header, prefix {seq, channel, 15}, then 16 words MSB byte first.
  task automatic push_packet(input int c);
    exp_hdr_t h;
    h.ip = dest_ip;
    h.port = dest_port;
    hq.push_back(h);
    hdr_budget++;
    for (int b = 3; b >= 0; b--) push_byte(m_seq[c][b*8 +: 8], 1'b0);
    push_byte(8'(c), 1'b0);
    push_byte(8'd15, 1'b0);
    for (int k = 0; k < 16; k++)
      for (int j = 0; j < 4; j++) push_byte(byte_of(c, m_ptr[c] + k, j), (k == 15 && j == 3));
    m_ptr[c] += 16;
    m_seq[c] += 32'd1;
  endtask

  task automatic clear_model();
    exp_q.delete();
    hq.delete();
    hdr_budget = 0;
    for (int c = 0; c < 4; c++) begin
      m_seq[c] = '0;
      m_ptr[c] = 0;
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset_n = 1'b0;
    src_en = '0;
    hold_hdr = 1'b0;
    gap_pct = 0;
    rdy_pct = 100;
    clear_model();
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
  endtask

  task automatic wait_drain(input int limit);
    int n = 0;
    while ((exp_q.size() != 0 || hdr_budget != 0) && n < limit) begin
      @(negedge clk);
      n++;
    end
    check("drain_remaining", 64'(exp_q.size()), 64'd0);
    @(negedge clk);
  endtask

  // Input sources, payload sink and header sink.
  initial begin
    in_tvalid = '0;
    in_tdata = '0;
    payload_tready = 1'b0;
    hdr_ready = 1'b0;
    forever begin
      @(negedge clk);
      for (int c = 0; c < 4; c++) begin
        if (!src_en[c]) in_tvalid[c] = 1'b0;
        else if (!in_tvalid[c] || src_hs[c]) in_tvalid[c] = ($urandom_range(0, 99) >= gap_pct);
        in_tdata[c] = word_of(c, src_ptr[c]);
      end
      payload_tready = ($urandom_range(0, 99) < rdy_pct);
      hdr_ready = !hold_hdr && (hdr_budget > 0);
      #4;
      for (int c = 0; c < 4; c++) begin
        src_hs[c] = reset_n && in_tvalid[c] && in_tready[c];
        if (!reset_n) src_ptr[c] = 0;
        else if (src_hs[c]) src_ptr[c]++;
      end
    end
  end

  // Output monitor.
  initial begin
    logic prev_stall, hprev_stall;
    logic [7:0] prev_data;
    logic [31:0] hprev_ip;
    exp_byte_t e;
    exp_hdr_t h;
    prev_stall = 1'b0;
    hprev_stall = 1'b0;
    prev_data = '0;
    hprev_ip = '0;
    forever begin
      @(negedge clk);
      #4;
      if (!reset_n) begin
        prev_stall = 1'b0;
        hprev_stall = 1'b0;
      end else begin
        if (prev_stall) begin
          check("tvalid_hold", 64'(payload_tvalid), 64'd1);
          check("tdata_hold", 64'(payload_tdata), 64'(prev_data));
        end
        if (payload_tvalid && payload_tready) begin
          pay_hs++;
          if (exp_q.size() == 0) check("payload_extra", 64'(payload_tvalid), 64'd0);
          else begin
            e = exp_q.pop_front();
            check("payload_data", 64'(payload_tdata), 64'(e.data));
            check("payload_last", 64'(payload_tlast), 64'(e.last));
            check("payload_side", {payload_tkeep, payload_tstrb, payload_tuser, payload_tid,
                                   payload_tdest}, 64'b11000);
          end
        end
        prev_stall = payload_tvalid && !payload_tready;
        prev_data = payload_tdata;
        if (hprev_stall) begin
          check("hdr_valid_hold", 64'(hdr_valid), 64'd1);
          check("hdr_ip_stable", 64'(hdr_dest_ip), 64'(hprev_ip));
        end
        if (hdr_valid && hdr_ready) begin
          if (hq.size() == 0) check("hdr_extra", 64'(hdr_valid), 64'd0);
          else begin
            h = hq.pop_front();
            hdr_budget--;
            check("hdr_dest_ip", 64'(hdr_dest_ip), 64'(h.ip));
            check("hdr_dest_port", 64'(hdr_dest_port), 64'(h.port));
            check("hdr_length", 64'(hdr_length), 64'd78);  // 8 + 6 + 16*4
            check("hdr_ttl", 64'(hdr_ttl), 64'd64);
            check("hdr_source_ip", 64'(hdr_source_ip), 64'hC0A8_0180);
            check("hdr_source_port", 64'(hdr_source_port), 64'd1234);
            check("hdr_zero_fields", {hdr_dscp, hdr_ecn, hdr_checksum}, 64'd0);
          end
        end
        hprev_stall = hdr_valid && !hdr_ready;
        hprev_ip = hdr_dest_ip;
        check("in_tready_onehot0", 64'($onehot0(in_tready)), 64'd1);
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    // Reset state
    #1;
    check("rst_hdr_valid", 64'(hdr_valid), 64'd0);
    check("rst_tvalid", 64'(payload_tvalid), 64'd0);
    check("rst_tlast", 64'(payload_tlast), 64'd0);
    check("rst_in_tready", 64'(in_tready), 64'd0);
    check("rst_count", 64'(tx_packet_count), 64'd0);
    repeat (3) @(negedge clk);
    reset_n = 1'b1;

    // Single channel 0 packet, sink always ready
    push_packet(0);
    src_en = 4'b0001;
    wait_drain(400);
    check("count_single", 64'(tx_packet_count), 64'd1);

    // All channels valid: grant order 0,1,2,3,0
    do_reset();
    push_packet(0);
    push_packet(1);
    push_packet(2);
    push_packet(3);
    push_packet(0);
    src_en = 4'b1111;
    wait_drain(2000);
    check("count_rr", 64'(tx_packet_count), 64'd5);

    // Random sink backpressure and input gaps
    do_reset();
    gap_pct = 30;
    rdy_pct = 50;
    push_packet(1);
    push_packet(1);
    push_packet(1);
    src_en = 4'b0010;
    wait_drain(5000);
    check("count_random", 64'(tx_packet_count), 64'd3);

    // Sequence wrap on channel 2
    do_reset();
    force dut.seq_q = {32'h0, 32'hFFFF_FFFF, 32'h0, 32'h0};
    @(negedge clk);
    release dut.seq_q;
    m_seq[2] = 32'hFFFF_FFFF;
    push_packet(2);
    push_packet(2);
    src_en = 4'b0100;
    wait_drain(1000);
    check("count_wrap", 64'(tx_packet_count), 64'd2);

    // Reset in the middle of the data phase
    do_reset();
    push_packet(0);
    src_en = 4'b0001;
    n = 0;
    while (pay_hs < 16 && n < 400) begin
      pay_hs = 0;
      while (pay_hs < 16 && n < 400) begin
        @(negedge clk);
        n++;
      end
    end
    check("midrst_progress", 64'(pay_hs >= 16), 64'd1);
    @(negedge clk);
    reset_n = 1'b0;
    #1;
    check("midrst_tvalid", 64'(payload_tvalid), 64'd0);
    check("midrst_tlast", 64'(payload_tlast), 64'd0);
    check("midrst_count", 64'(tx_packet_count), 64'd0);
    check("midrst_hdr_valid", 64'(hdr_valid), 64'd0);
    check("midrst_in_tready", 64'(in_tready), 64'd0);
    clear_model();
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    push_packet(0);
    wait_drain(400);
    check("count_after_rst", 64'(tx_packet_count), 64'd1);

    // Header held off while dest_ip wanders
    do_reset();
    dest_ip = 32'hAC10_0505;
    hold_hdr = 1'b1;
    push_packet(1);
    src_en = 4'b0010;
    n = 0;
    while (!hdr_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("hold_hdr_seen", 64'(hdr_valid), 64'd1);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      dest_ip = $urandom;
      #4;
      check("hold_dest_ip", 64'(hdr_dest_ip), 64'hAC10_0505);
      check("hold_hdr_valid", 64'(hdr_valid), 64'd1);
      check("hold_no_payload", 64'(payload_tvalid), 64'd0);
      check("hold_no_tready", 64'(in_tready), 64'd0);
    end
    hold_hdr = 1'b0;
    wait_drain(400);
    check("count_hold", 64'(tx_packet_count), 64'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
